// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited requests to
// instruction memory, buffers responses and drives the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall_D,
    input  logic        flush_D,
    output logic [31:0] instruction_D,
    output logic [31:0] pc_D,
    output logic [31:0] pc_plus4_D,
    output logic        valid_D
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic             active_q;
    logic [31:0]      pc_f_q, pc_f_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [PTR_W-1:0] pend_rd_q, pend_rd_d;
    logic [PTR_W-1:0] pend_wr_q, pend_wr_d;

    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_valid_q, id_valid_d;

    logic [FIFO_DEPTH-1:0][31:0] fifo_pc_w;
    logic [FIFO_DEPTH-1:0][31:0] fifo_data_w;
    logic [FIFO_DEPTH-1:0][31:0] pend_pc_w;

    logic [CNT_W:0] credit_used;
    logic           req_fire;
    logic           rsp_keep;
    logic           fifo_empty;
    logic           id_kill;
    logic           id_load;
    logic           fifo_pop;
    logic           fifo_push;
    logic           bypass;
    logic [31:0]    rsp_pc;

    // Every in-flight request plus every buffered entry holds one credit, so a
    // response always has a FIFO slot waiting for it.
    assign credit_used    = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
    assign imem_req_valid = active_q && !redirect && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_f_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && (discard_q == '0);
    assign rsp_pc     = pend_pc_w[pend_rd_q];
    assign fifo_empty = (fifo_cnt_q == '0);

    assign id_kill   = redirect || flush_D;
    assign id_load   = !id_kill && !stall_D;
    assign fifo_pop  = id_load && !fifo_empty;
    assign bypass    = id_load && fifo_empty && rsp_keep;
    assign fifo_push = rsp_keep && !redirect && !bypass;

    always_comb begin
        pc_f_d     = pc_f_q;
        outst_d    = outst_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
        discard_d  = discard_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        pend_rd_d  = pend_rd_q + PTR_W'(imem_rsp_valid);
        pend_wr_d  = pend_wr_q + PTR_W'(req_fire);

        if (redirect) begin
            pc_f_d     = redirect_pc & ~32'h0000_0003;
            // Whatever is still in flight after this cycle belongs to the old path.
            discard_d  = outst_q - CNT_W'(imem_rsp_valid);
            fifo_cnt_d = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
        end else begin
            if (req_fire) begin
                pc_f_d = pc_f_q + 32'd4;
            end
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
            fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
            fifo_rd_d  = fifo_rd_q + PTR_W'(fifo_pop);
            fifo_wr_d  = fifo_wr_q + PTR_W'(fifo_push);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            pc_f_q     <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            fifo_cnt_q <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= '0;
        end else begin
            active_q   <= 1'b1;
            pc_f_q     <= pc_f_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            pend_rd_q  <= pend_rd_d;
            pend_wr_q  <= pend_wr_d;
        end
    end

    // One slot of the prefetch FIFO and of the pending-PC queue per entry.
    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [31:0] fifo_pc_q;
            logic [31:0] fifo_data_q;
            logic [31:0] pend_pc_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fifo_pc_q   <= '0;
                    fifo_data_q <= '0;
                    pend_pc_q   <= '0;
                end else begin
                    if (fifo_push && (fifo_wr_q == PTR_W'(gi))) begin
                        fifo_pc_q   <= rsp_pc;
                        fifo_data_q <= imem_rsp_data;
                    end
                    if (req_fire && (pend_wr_q == PTR_W'(gi))) begin
                        pend_pc_q <= pc_f_q;
                    end
                end
            end

            assign fifo_pc_w[gi]   = fifo_pc_q;
            assign fifo_data_w[gi] = fifo_data_q;
            assign pend_pc_w[gi]   = pend_pc_q;
        end
    endgenerate

    // IF/ID register: kill beats stall, buffered entries beat the bypass path.
    always_comb begin
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
        if (id_kill) begin
            id_instr_d = '0;
            id_valid_d = 1'b0;
        end else if (!stall_D) begin
            if (fifo_pop) begin
                id_instr_d = fifo_data_w[fifo_rd_q];
                id_pc_d    = fifo_pc_w[fifo_rd_q];
                id_pc4_d   = fifo_pc_w[fifo_rd_q] + 32'd4;
                id_valid_d = 1'b1;
            end else if (bypass) begin
                id_instr_d = imem_rsp_data;
                id_pc_d    = rsp_pc;
                id_pc4_d   = rsp_pc + 32'd4;
                id_valid_d = 1'b1;
            end else begin
                id_instr_d = '0;
                id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_instr_q <= '0;
            id_pc_q    <= '0;
            id_pc4_q   <= 32'd4;
            id_valid_q <= 1'b0;
        end else begin
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign instruction_D = id_instr_q;
    assign pc_D          = id_pc_q;
    assign pc_plus4_D    = id_pc4_q;
    assign valid_D       = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed table, redirect/wrap/async-reset sequences and
// randomized traffic against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_D;
    logic        flush_D;
    logic [31:0] instruction_D;
    logic [31:0] pc_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;

    fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .stall_D        (stall_D),
        .flush_D        (flush_D),
        .instruction_D  (instruction_D),
        .pc_D           (pc_D),
        .pc_plus4_D     (pc_plus4_D),
        .valid_D        (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat_lo = 1, lat_hi = 1, rsp_pct = 100;
    bit use_model = 0;
    logic        obs_rv;
    logic [31:0] obs_addr;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { bit st; bit fl; bit rv; logic [31:0] addr; bit vd; logic [31:0] pc; } vec_t;

    mreq_t mem_q[$];
    infl_t m_infl[$];
    ent_t  m_fifo[$];
    logic [31:0] m_pc, m_instr, m_dpc;
    bit          m_valid, m_active;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        else if (a == 32'h4) return 32'h00A0_0113;
        else return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic vec_t mkv(input bit st, input bit fl, input bit rv,
                                 input logic [31:0] addr, input bit vd, input logic [31:0] pc);
        vec_t v;
        v.st = st; v.fl = fl; v.rv = rv; v.addr = addr; v.vd = vd; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_bound(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_active = 0;
        m_instr = '0; m_dpc = '0; m_valid = 0;
        m_infl.delete(); m_fifo.delete(); mem_q.delete();
        cyc = 0;
    endtask

    // Reference: every request is remembered with its PC; a redirect marks all of
    // them stale; the buffer is a plain queue sitting in front of the ID register.
    function automatic void model_update(input bit rd, input logic [31:0] rpc, input bit st,
                                         input bit fl, input bit fire, input bit rsp_v,
                                         input logic [31:0] rsp_d);
        bit    live = 0;
        ent_t  r;
        infl_t h;
        r.pc = '0; r.data = '0;
        if (rsp_v && m_infl.size() > 0) begin
            h = m_infl.pop_front();
            live = !h.stale;
            r.pc = h.pc; r.data = rsp_d;
        end
        if (rd) begin
            foreach (m_infl[i]) m_infl[i].stale = 1;
            m_fifo.delete();
            m_instr = '0; m_valid = 0;
            m_pc = rpc & ~32'h3;
        end else begin
            if (fl || st) begin
                if (fl) begin m_instr = '0; m_valid = 0; end
                if (live) m_fifo.push_back(r);
            end else if (m_fifo.size() > 0) begin
                ent_t e = m_fifo.pop_front();
                m_instr = e.data; m_dpc = e.pc; m_valid = 1;
                if (live) m_fifo.push_back(r);
            end else if (live) begin
                m_instr = r.data; m_dpc = r.pc; m_valid = 1;
            end else begin
                m_instr = '0; m_valid = 0;
            end
            if (fire) begin
                infl_t n;
                n.pc = m_pc; n.stale = 0;
                m_infl.push_back(n);
                m_pc = m_pc + 32'd4;
            end
        end
        m_active = 1;
    endfunction

    task automatic step(input bit rd, input logic [31:0] rpc, input bit st, input bit fl, input bit rdy);
        bit          exp_rv;
        bit          rsp_v;
        logic [31:0] rsp_d;
        mreq_t       nq;
        redirect = rd; redirect_pc = rpc; stall_D = st; flush_D = fl; imem_req_ready = rdy;
        rsp_v = 0; rsp_d = $urandom;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99, 0) < rsp_pct) begin
            rsp_v = 1;
            rsp_d = rom(mem_q[0].addr);
            mem_q.delete(0);
        end
        imem_rsp_valid = rsp_v; imem_rsp_data = rsp_d;
        #1;
        obs_rv = imem_req_valid; obs_addr = imem_req_addr;
        exp_rv = m_active && !rd && ((m_infl.size() + m_fifo.size()) < DEPTH);
        if (use_model) begin
            chk("req_valid", obs_rv, exp_rv);
            chk("req_addr", obs_addr, m_pc);
        end
        if (obs_rv && rdy) begin
            nq.addr = obs_addr;
            nq.due  = cyc + $urandom_range(lat_hi, lat_lo);
            mem_q.push_back(nq);
        end
        model_update(rd, rpc, st, fl, exp_rv && rdy, rsp_v, rsp_d);
        @(posedge clk); #1;
        if (use_model) begin
            chk("instruction_D", instruction_D, m_instr);
            chk("valid_D", valid_D, m_valid);
            chk("pc_D", pc_D, m_dpc);
            chk("pc_plus4_D", pc_plus4_D, m_dpc + 32'd4);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_instr"}, instruction_D, 32'h0);
        chk({tag, "_pc"}, pc_D, 32'h0);
        chk({tag, "_pc4"}, pc_plus4_D, 32'h4);
        chk({tag, "_valid"}, valid_D, 1'b0);
        chk({tag, "_req_valid"}, imem_req_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 0; redirect = 0; redirect_pc = '0; stall_D = 0; flush_D = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        bit   found;

        // Streaming with zero-wait memory, 3-cycle stall, then flush+stall together.
        tbl[0]  = mkv(0, 0, 0, 32'h00, 0, 32'h00);
        tbl[1]  = mkv(0, 0, 1, 32'h00, 0, 32'h00);
        tbl[2]  = mkv(0, 0, 1, 32'h04, 1, 32'h00);
        tbl[3]  = mkv(0, 0, 1, 32'h08, 1, 32'h04);
        tbl[4]  = mkv(1, 0, 1, 32'h0C, 1, 32'h04);
        tbl[5]  = mkv(1, 0, 0, 32'h10, 1, 32'h04);
        tbl[6]  = mkv(1, 0, 0, 32'h10, 1, 32'h04);
        tbl[7]  = mkv(0, 0, 0, 32'h10, 1, 32'h08);
        tbl[8]  = mkv(0, 0, 1, 32'h10, 1, 32'h0C);
        tbl[9]  = mkv(0, 0, 1, 32'h14, 1, 32'h10);
        tbl[10] = mkv(0, 0, 1, 32'h18, 1, 32'h14);
        tbl[11] = mkv(1, 1, 1, 32'h1C, 0, 32'h14);
        tbl[12] = mkv(0, 0, 0, 32'h20, 1, 32'h18);
        tbl[13] = mkv(0, 0, 1, 32'h20, 1, 32'h1C);
        tbl[14] = mkv(0, 0, 1, 32'h24, 1, 32'h20);

        use_model = 0; lat_lo = 1; lat_hi = 1; rsp_pct = 100;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(0, '0, tbl[i].st, tbl[i].fl, 1);
            chk($sformatf("t%0d_req_valid", i), obs_rv, tbl[i].rv);
            chk($sformatf("t%0d_req_addr", i), obs_addr, tbl[i].addr);
            chk($sformatf("t%0d_valid_D", i), valid_D, tbl[i].vd);
            chk($sformatf("t%0d_instr", i), instruction_D, tbl[i].vd ? rom(tbl[i].pc) : 32'h0);
            chk($sformatf("t%0d_pc_D", i), pc_D, tbl[i].pc);
            chk($sformatf("t%0d_pc4_D", i), pc_plus4_D, tbl[i].pc + 32'd4);
            $display("vec %0d: st=%0b fl=%0b req=%0b addr=%h valid_D=%0b pc_D=%h instr=%h",
                     i, tbl[i].st, tbl[i].fl, obs_rv, obs_addr, valid_D, pc_D, instruction_D);
        end

        // Redirect with two requests in flight: both stale responses must vanish.
        use_model = 1; lat_lo = 4; lat_hi = 4; rsp_pct = 100;
        do_reset();
        repeat (3) step(0, '0, 0, 0, 1);
        step(1, 32'h0000_0103, 0, 0, 1);
        chk("redir_no_req", obs_rv, 1'b0);
        step(0, '0, 0, 0, 1);
        chk("redir_addr", obs_addr, 32'h0000_0100);
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (valid_D) begin found = 1; break; end
            step(0, '0, 0, 0, 1);
        end
        if (found) begin
            chk("redir_first_pc", pc_D, 32'h0000_0100);
            chk("redir_first_instr", instruction_D, rom(32'h0000_0100));
        end else fail_bound("redir_first_valid");
        $display("redirect seq: first valid pc_D=%h", pc_D);

        // PC wrap at the top of the address space.
        lat_lo = 1; lat_hi = 1;
        step(1, 32'hFFFF_FFFF, 0, 0, 1);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, '0, 0, 0, 1);
            if (obs_rv) begin found = 1; break; end
        end
        if (found) begin
            chk("wrap_pre_addr", obs_addr, 32'hFFFF_FFFC);
            step(0, '0, 0, 0, 1);
            chk("wrap_addr", obs_addr, 32'h0000_0000);
        end else fail_bound("wrap_issue");
        $display("wrap seq: addr after FFFFFFFC = %h", obs_addr);

        // Randomized traffic against the reference model.
        lat_lo = 1; lat_hi = 4; rsp_pct = 70;
        for (int k = 0; k < 3000; k++) begin
            bit rd, st, fl, rdy;
            rd  = ($urandom_range(99, 0) < 4);
            st  = ($urandom_range(99, 0) < 20);
            fl  = ($urandom_range(99, 0) < 5);
            rdy = ($urandom_range(99, 0) < 75);
            step(rd, $urandom, st, fl, rdy);
        end
        $display("random phase done at cycle %0d, errors so far %0d", cyc, n_err);

        // Asynchronous reset mid-stream with two requests outstanding.
        lat_lo = 3; lat_hi = 3; rsp_pct = 100;
        do_reset();
        repeat (6) step(0, '0, 0, 0, 1);
        step(0, '0, 1, 0, 1);
        chk("pre_rst_valid", valid_D, 1'b1);
        chk("pre_rst_pc", pc_D, 32'h4);
        #2 rst_n = 0;
        #1 check_reset_outputs("async");
        $display("async reset: instr=%h pc_D=%h valid_D=%0b req_valid=%0b",
                 instruction_D, pc_D, valid_D, imem_req_valid);
        @(posedge clk);
        @(negedge clk);
        stall_D = 0; redirect = 0; flush_D = 0; imem_rsp_valid = 0;
        rst_n = 1;
        model_reset();
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);
        chk("restart_req_valid", obs_rv, 1'b1);
        chk("restart_addr", obs_addr, RESET_PC);
        found = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid_D) begin found = 1; break; end
            step(0, '0, 0, 0, 1);
        end
        if (found) chk("restart_first_pc", pc_D, RESET_PC);
        else fail_bound("restart_first_valid");
        $display("restart: first valid pc_D=%h", pc_D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
